// File: rtl/run_ctrl_pkg.sv
// Shared state encodings and parameter defaults for the CPU run controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUN     = 2'd1,
    ST_STEP    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  // 10 ms of stable level at a 4 MHz system clock
  localparam int DEB_CYCLES_DEF = 40000;
  localparam int CNT_W_DEF      = 16;

  function automatic logic cpu_active(input state_t s);
    return s != ST_STOPPED;
  endfunction

  function automatic logic led_on(input state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, press pulse.
module debounce
  import run_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam logic [CNT_W-1:0] LP_LAST =
    CNT_W'(DEB_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_flip;

  assign w_diff = r_s2 != r_level;
  assign w_flip = w_diff && (r_cnt == LP_LAST);

  // Pulse is registered alongside the level so it aligns with the 0->1 edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_btn;
      r_s2    <= r_s1;
      r_press <= w_flip && r_s2;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_cnt   <= '0;
        r_level <= r_s2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/run_ctrl.sv
// Front-panel run/stop/step controller producing the CPU clock enable.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_stop,
  input  logic       btn_step,
  input  logic       instr_done,
  input  logic       halt_req,
  output logic       cpu_en,
  output logic       running,
  output logic [1:0] state_o
);

  logic   w_run_p;
  logic   w_stop_p;
  logic   w_step_p;
  state_t r_state;
  state_t w_next;
  logic   r_cpu_en;

  debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deb_run (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_run),
    .o_press(w_run_p)
  );

  debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deb_stop (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_stop),
    .o_press(w_stop_p)
  );

  debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deb_step (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_step),
    .o_press(w_step_p)
  );

  // Priority: halt_req > instr_done > stop > step > run
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_STOPPED: begin
        if (w_step_p)
          w_next = ST_STEP;
        else if (w_run_p)
          w_next = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req)
          w_next = ST_STOPPED;
        else if (w_stop_p)
          w_next = ST_DRAIN;
      end
      ST_STEP,
      ST_DRAIN: begin
        if (halt_req || instr_done)
          w_next = ST_STOPPED;
      end
    endcase
  end

  // Enable tracks the next state so it drops on the terminating edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_STOPPED;
      r_cpu_en <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cpu_en <= cpu_active(w_next);
    end
  end

  assign cpu_en  = r_cpu_en;
  assign running = led_on(r_state);
  assign state_o = r_state;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: vector table, directed corners, random vs reference model.
module tb_run_ctrl;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_run = 1'b0;
  logic       btn_stop = 1'b0;
  logic       btn_step = 1'b0;
  logic       instr_done = 1'b0;
  logic       halt_req = 1'b0;
  logic       cpu_en;
  logic       running;
  logic [1:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  run_ctrl #(
    .DEB_CYCLES(DEB),
    .CNT_W     (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_run   (btn_run),
    .btn_stop  (btn_stop),
    .btn_step  (btn_step),
    .instr_done(instr_done),
    .halt_req  (halt_req),
    .cpu_en    (cpu_en),
    .running   (running),
    .state_o   (state_o)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: raw sample history per edge, window test for level
  logic [2:0] rq[$];
  logic [2:0] lvl;
  logic [2:0] prs;
  int         mst;

  // Targets per state for events ordered halt, done, stop, step, run
  int tgt [4][5] = '{
    '{-1, -1, -1,  2,  1},
    '{ 0, -1,  3, -1, -1},
    '{ 0,  0, -1, -1, -1},
    '{ 0,  0, -1, -1, -1}
  };

  function automatic int fsm_next(input int s, input logic [4:0] ev);
    for (int i = 0; i < 5; i++)
      if (ev[4-i] && tgt[s][i] >= 0)
        return tgt[s][i];
    return s;
  endfunction

  task automatic model_reset();
    rq.delete();
    repeat (DEB + 2) rq.push_back(3'b000);
    lvl = '0;
    prs = '0;
    mst = 0;
  endtask

  task automatic model_edge();
    logic [4:0] ev;
    logic [2:0] v;
    bit         flip;
    ev  = {halt_req, instr_done, prs[1], prs[2], prs[0]};
    mst = fsm_next(mst, ev);
    rq.push_back({btn_step, btn_stop, btn_run});
    if (rq.size() > 16) void'(rq.pop_front());
    prs = '0;
    for (int b = 0; b < 3; b++) begin
      flip = 1'b1;
      for (int k = 0; k < DEB; k++) begin
        v = rq[rq.size() - 3 - k];
        if (v[b] == lvl[b]) flip = 1'b0;
      end
      if (flip) begin
        lvl[b] = ~lvl[b];
        prs[b] = lvl[b];
      end
    end
  endtask

  task automatic step();
    logic [1:0] ms;
    logic       en_m;
    logic       led_m;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    ms    = 2'(mst);
    en_m  = (mst != 0);
    led_m = (mst == 1) || (mst == 3);
    chk("model", int'({state_o, cpu_en, running}),
        int'({ms, en_m, led_m}));
  endtask

  task automatic async_reset();
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async rst en", int'(cpu_en), 0);
    chk("async rst st", int'(state_o), 0);
    chk("async rst led", int'(running), 0);
    repeat (2) step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic run;
    logic stop;
    logic stp;
    logic done;
    logic halt;
    int   cyc;
    int   st;
    int   en;
    int   led;
  } vec_t;

  vec_t tbl [18];

  int n_en;
  int seen;
  int hr, hs, hp;

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 6, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 1, 1, 1, 1};
    tbl[4]  = '{1, 0, 0, 0, 0, 3, 1, 1, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 8, 1, 1, 1};
    tbl[6]  = '{0, 1, 0, 0, 0, 6, 1, 1, 1};
    tbl[7]  = '{0, 1, 0, 0, 0, 1, 3, 1, 1};
    tbl[8]  = '{0, 0, 0, 0, 0, 6, 3, 1, 1};
    tbl[9]  = '{0, 0, 0, 1, 0, 1, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 0, 7, 1, 1, 1};
    tbl[12] = '{0, 1, 0, 0, 0, 6, 1, 1, 1};
    tbl[13] = '{0, 1, 0, 0, 1, 1, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[15] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    tbl[16] = '{1, 0, 1, 0, 0, 7, 2, 1, 0};
    tbl[17] = '{0, 0, 0, 1, 0, 1, 0, 0, 0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", int'(state_o), 0);
    chk("reset en", int'(cpu_en), 0);
    chk("reset led", int'(running), 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      btn_run    = tbl[i].run;
      btn_stop   = tbl[i].stop;
      btn_step   = tbl[i].stp;
      instr_done = tbl[i].done;
      halt_req   = tbl[i].halt;
      repeat (tbl[i].cyc) step();
      chk($sformatf("vec%0d state", i), int'(state_o), tbl[i].st);
      chk($sformatf("vec%0d en", i), int'(cpu_en), tbl[i].en);
      chk($sformatf("vec%0d led", i), int'(running), tbl[i].led);
    end
    {btn_run, btn_stop, btn_step, instr_done, halt_req} = '0;

    repeat (8) step();
    for (int r = 0; r < 2; r++) begin
      btn_step = 1'b1;
      repeat (6) step();
      chk("step pre", int'(state_o), 0);
      btn_step = 1'b0;
      n_en = 0;
      repeat (5) begin
        step();
        if (cpu_en) n_en++;
      end
      instr_done = 1'b1;
      step();
      instr_done = 1'b0;
      chk("step en cycles", n_en, 5);
      chk("step end state", int'(state_o), 0);
      chk("step end en", int'(cpu_en), 0);
      repeat (8) step();
    end

    btn_step = 1'b1;
    repeat (3) step();
    btn_step = 1'b0;
    seen = 0;
    repeat (10) begin
      step();
      if (state_o != 2'd0) seen = 1;
    end
    chk("glitch state", seen, 0);

    repeat (8) step();
    btn_step = 1'b1;
    repeat (7) step();
    btn_step = 1'b0;
    chk("into step", int'(state_o), 2);
    btn_run = 1'b1;
    async_reset();
    repeat (6) step();
    chk("post rst wait", int'(state_o), 0);
    step();
    chk("post rst run", int'(state_o), 1);
    chk("post rst en", int'(cpu_en), 1);
    btn_run = 1'b0;

    hr = 0;
    hs = 0;
    hp = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hr == 0) begin
        btn_run = 1'($urandom_range(0, 1));
        hr = $urandom_range(1, 10);
      end else hr--;
      if (hs == 0) begin
        btn_stop = 1'($urandom_range(0, 1));
        hs = $urandom_range(1, 10);
      end else hs--;
      if (hp == 0) begin
        btn_step = 1'($urandom_range(0, 1));
        hp = $urandom_range(1, 10);
      end else hp--;
      instr_done = ($urandom_range(0, 7) == 0);
      halt_req   = ($urandom_range(0, 31) == 0);
      step();
      if (i == 1500) async_reset();
    end
    {btn_run, btn_stop, btn_step, instr_done, halt_req} = '0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
